nco_wavegen: RTL and testbench

- Parametrised successor to the single-channel sine lookup: a full numerically controlled oscillator.
- Contains a phase accumulator with frequency tuning word and phase offset, plus a selectable waveform (sine, square, triangle, sawtooth).
- Pipelined output with a valid strobe.
- Feeds the PWM/DAC output path; all samples are unsigned offset-binary with midscale 2^(OUT_W-1).

---
 rtl/nco_wavegen.sv | 188 ++++++++++++++++++
 tb/tb_nco_wavegen.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_wavegen.sv
// nco_wavegen: phase-accumulator NCO with sine (quarter-wave LUT), square, triangle and sawtooth.
// Define NCO_AMPLITUDE_SCALE_EN to add an amplitude input and one gain stage (latency 3 -> 4).
module nco_wavegen #(
  parameter int PHASE_W    = 32,
  parameter int LUT_ADDR_W = 8,
  parameter int OUT_W      = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               sync_clear,
  input  logic [PHASE_W-1:0] ftw,
  input  logic [PHASE_W-1:0] phase_offset,
  input  logic [1:0]         mode,
`ifdef NCO_AMPLITUDE_SCALE_EN
  input  logic [OUT_W-1:0]   amplitude,
`endif
  output logic [OUT_W-1:0]   sample,
  output logic               sample_valid
);

  // Only the top phase bits feed any waveform: sine address, or triangle (MSB + OUT_W below it).
  localparam int P1_W = (LUT_ADDR_W > OUT_W + 1) ? LUT_ADDR_W : OUT_W + 1;
  localparam int QA_W = LUT_ADDR_W - 2;
  localparam int QN   = 1 << QA_W;
  localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};
  localparam longint AMP = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;

  typedef enum logic [1:0] {
    MODE_SINE   = 2'b00,
    MODE_SQUARE = 2'b01,
    MODE_TRI    = 2'b10,
    MODE_SAW    = 2'b11
  } mode_e;

  // Elaboration-time round(AMP*sin(2*pi*k/2^LUT_ADDR_W)) in 2^30 fixed point via Taylor series.
  function automatic logic [OUT_W-2:0] sine_q(input int k);
    longint x;
    longint term;
    longint sum;
    longint r;
    x    = (64'sd6746518852 * longint'(k)) >>> LUT_ADDR_W;
    term = x;
    sum  = x;
    for (int n = 1; n <= 10; n++) begin
      term = -((((term * x) >>> 30) * x) >>> 30) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    r = (sum * AMP + (64'sd1 <<< 29)) >>> 30;
    return (OUT_W-1)'(r);
  endfunction

  logic [OUT_W-2:0] qtab [QN+1];

  for (genvar g = 0; g <= QN; g++) begin : g_qtab
    localparam logic [OUT_W-2:0] QV = sine_q(g);
    assign qtab[g] = QV;
  end

  // Stage A: accumulator. Clear outranks enable and suppresses that cycle's sample.
  logic [PHASE_W-1:0] acc_q;
  logic [P1_W-1:0]    p1_q;
  mode_e              mode1_q;
  logic               v1_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q   <= '0;
      p1_q    <= '0;
      mode1_q <= MODE_SINE;
      v1_q    <= 1'b0;
    end else if (sync_clear) begin
      acc_q <= '0;
      v1_q  <= 1'b0;
    end else if (enable) begin
      p1_q    <= P1_W'((acc_q + phase_offset) >> (PHASE_W - P1_W));
      mode1_q <= mode_e'(mode);
      v1_q    <= 1'b1;
      acc_q   <= acc_q + ftw;
    end else begin
      v1_q <= 1'b0;
    end
  end

  // Stage B: waveform compute.
  logic [LUT_ADDR_W-1:0] lut_a;
  logic [1:0]            quad;
  logic [QA_W-1:0]       q_idx;
  logic [QA_W:0]         q_addr;
  logic [OUT_W-2:0]      q_mag;
  logic [OUT_W-1:0]      tri_t;
  logic [OUT_W-1:0]      wave_d;

  always_comb begin
    lut_a  = p1_q[P1_W-1 -: LUT_ADDR_W];
    quad   = lut_a[LUT_ADDR_W-1 -: 2];
    q_idx  = lut_a[QA_W-1:0];
    q_addr = quad[0] ? ((QA_W+1)'(QN) - {1'b0, q_idx}) : {1'b0, q_idx};
    q_mag  = qtab[q_addr];
    tri_t  = p1_q[P1_W-2 -: OUT_W];
    wave_d = '0;
    case (mode1_q)
      MODE_SINE:   wave_d = quad[1] ? (MID - {1'b0, q_mag}) : (MID + {1'b0, q_mag});
      MODE_SQUARE: wave_d = p1_q[P1_W-1] ? '0 : '1;
      MODE_TRI:    wave_d = p1_q[P1_W-1] ? ~tri_t : tri_t;
      default:     wave_d = p1_q[P1_W-1 -: OUT_W];
    endcase
  end

  logic [OUT_W-1:0] p2_q;
  logic             v2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p2_q <= '0;
      v2_q <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) p2_q <= wave_d;
    end
  end

  logic [OUT_W-1:0] fin_wave;
  logic             fin_v;

`ifdef NCO_AMPLITUDE_SCALE_EN
  localparam int PW = 2 * OUT_W + 2;
  localparam logic signed [PW-1:0] LIM = PW'(AMP);

  logic signed [PW-1:0] diff_w;
  logic signed [PW-1:0] amp_w;
  logic signed [PW-1:0] prod_w;
  logic signed [PW-1:0] shift_w;
  logic [OUT_W-1:0]     scaled_d;
  logic [OUT_W-1:0]     s3_q;
  logic                 v3_q;

  // Signed gain around midscale; amplitude = MID is unity, result clamped to +/-AMP.
  always_comb begin
    diff_w  = PW'($signed({1'b0, p2_q}) - $signed({1'b0, MID}));
    amp_w   = PW'({1'b0, amplitude});
    prod_w  = diff_w * amp_w;
    shift_w = prod_w >>> (OUT_W - 1);
    if (shift_w > LIM) begin
      scaled_d = '1;
    end else if (shift_w < -LIM) begin
      scaled_d = {{(OUT_W-1){1'b0}}, 1'b1};
    end else begin
      scaled_d = shift_w[OUT_W-1:0] + MID;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s3_q <= '0;
      v3_q <= 1'b0;
    end else begin
      v3_q <= v2_q;
      if (v2_q) s3_q <= scaled_d;
    end
  end

  assign fin_wave = s3_q;
  assign fin_v    = v3_q;
`else
  assign fin_wave = p2_q;
  assign fin_v    = v2_q;
`endif

  // Output handshake: sample_valid is a one-cycle strobe per issued sample with no backpressure;
  // the consumer must take sample on every cycle sample_valid is high. sample holds otherwise.
  logic [OUT_W-1:0] sample_q;
  logic             sample_valid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      sample_valid_q <= fin_v;
      if (fin_v) sample_q <= fin_wave;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_nco_wavegen.sv
// Directed self-checking bench for nco_wavegen (default parameters, OUT_W=8, LUT_ADDR_W=8).
module tb_nco_wavegen;
  localparam int PHASE_W = 32;
  localparam int OUT_W   = 8;
`ifdef NCO_AMPLITUDE_SCALE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic               clk;
  logic               reset_n;
  logic               enable;
  logic               sync_clear;
  logic [PHASE_W-1:0] ftw;
  logic [PHASE_W-1:0] phase_offset;
  logic [1:0]         mode;
  logic [OUT_W-1:0]   sample;
  logic               sample_valid;
`ifdef NCO_AMPLITUDE_SCALE_EN
  logic [OUT_W-1:0]   amplitude;
`endif

  nco_wavegen dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .sync_clear   (sync_clear),
    .ftw          (ftw),
    .phase_offset (phase_offset),
    .mode         (mode),
`ifdef NCO_AMPLITUDE_SCALE_EN
    .amplitude    (amplitude),
`endif
    .sample       (sample),
    .sample_valid (sample_valid)
  );

  int errors = 0;
  int checks = 0;
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] got_q[$];
  logic [1:0]       mode_seq[$];
  logic [7:0]       mode_tab [3][4];

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_acc();
    enable     = 1'b0;
    sync_clear = 1'b1;
    step();
    sync_clear = 1'b0;
  endtask

  task automatic run_enabled(input int n_en, input int clr_at, input int n_cyc);
    got_q.delete();
    for (int c = 0; c < n_cyc; c++) begin
      enable     = (c < n_en);
      sync_clear = (c == clr_at);
      if (mode_seq.size() > 0 && c < n_en) mode = mode_seq[c % mode_seq.size()];
      step();
      if (sample_valid) got_q.push_back(sample);
    end
    enable     = 1'b0;
    sync_clear = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sample !== 8'd0) begin
      errors++; $display("FAIL reset_sample: got %0d expected 0", sample);
    end
    checks++;
    if (sample_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %0b expected 0", sample_valid);
    end
    enable = 1'b1;
    repeat (LAT + 1) step();
    checks++;
    if (sample_valid !== 1'b0 || sample !== 8'd0) begin
      errors++; $display("FAIL reset_hold: got valid=%0b sample=%0d expected 0/0", sample_valid, sample);
    end
    enable  = 1'b0;
    reset_n = 1'b1;
    step();
    checks++;
    if (sample_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release_valid: got %0b expected 0", sample_valid);
    end
  endtask

  task automatic test_sine_ramp();
    int k;
    int e;
    ftw = 32'h0100_0000; phase_offset = '0; mode = 2'b00;
    clear_acc();
    enable = 1'b1;
    for (int c = 0; c < 256 + LAT; c++) begin
      step();
      k = c - (LAT - 1);
      checks++;
      if (sample_valid !== (k >= 0)) begin
        errors++; $display("FAIL ramp_valid c=%0d: got %0b expected %0b", c, sample_valid, (k >= 0));
      end
      case (k)
        0:   e = 128;
        1:   e = 131;
        2:   e = 134;
        3:   e = 137;
        32:  e = 218;
        64:  e = 255;
        96:  e = 218;
        128: e = 128;
        160: e = 38;
        192: e = 1;
        255: e = 125;
        256: e = 128;
        default: e = -1;
      endcase
      if (e >= 0) begin
        checks++;
        if (sample !== 8'(e)) begin
          errors++; $display("FAIL ramp_sample k=%0d: got %0d expected %0d", k, sample, e);
        end
      end
    end
    enable = 1'b0;
    repeat (LAT + 1) step();
  endtask

  task automatic test_offset();
    ftw = 32'h0100_0000; phase_offset = 32'h4000_0000; mode = 2'b00;
    mode_seq.delete();
    exp_q = '{8'd255, 8'd255};
    clear_acc();
    run_enabled(2, -1, 2 + LAT + 1);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL offset_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL offset_sample[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]);
      end
    end
    phase_offset = '0;
  endtask

  task automatic test_modes();
    mode_tab = '{'{8'd255, 8'd255, 8'd0, 8'd0},
                 '{8'd0, 8'd128, 8'd255, 8'd127},
                 '{8'd0, 8'd64, 8'd128, 8'd192}};
    ftw = 32'h4000_0000; phase_offset = '0;
    for (int m = 1; m < 4; m++) begin
      mode_seq.delete();
      mode_seq.push_back(2'(m));
      exp_q.delete();
      for (int r = 0; r < 2; r++)
        for (int i = 0; i < 4; i++) exp_q.push_back(mode_tab[m-1][i]);
      clear_acc();
      run_enabled(8, -1, 8 + LAT + 1);
      checks++;
      if (got_q.size() !== exp_q.size()) begin
        errors++; $display("FAIL mode%0d_count: got %0d expected %0d", m, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL mode%0d_sample[%0d]: got %0d expected %0d", m, i, got_q[i], exp_q[i]);
        end
      end
    end
    mode_seq.delete();
  endtask

  task automatic test_mode_pipeline();
    ftw = 32'h4000_0000; phase_offset = '0;
    mode_seq = '{2'b01, 2'b10, 2'b11, 2'b00};
    exp_q    = '{8'd255, 8'd128, 8'd128, 8'd1};
    clear_acc();
    run_enabled(4, -1, 4 + LAT + 1);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL modemix_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL modemix_sample[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]);
      end
    end
    mode_seq.delete();
    mode = 2'b00;
  endtask

  task automatic test_enable_toggle();
    int   pulses;
    logic exp_v;
    logic [7:0] exp_s;
    ftw = 32'h0100_0000; phase_offset = '0; mode = 2'b00;
    pulses = 0;
    clear_acc();
    for (int c = 0; c < LAT + 5; c++) begin
      enable = (c == 0 || c == 2);
      step();
      exp_v = (c == LAT - 1 || c == LAT + 1);
      checks++;
      if (sample_valid !== exp_v) begin
        errors++; $display("FAIL toggle_valid c=%0d: got %0b expected %0b", c, sample_valid, exp_v);
      end
      if (sample_valid) pulses++;
      if (c >= LAT - 1) begin
        exp_s = (c >= LAT + 1) ? 8'd131 : 8'd128;
        checks++;
        if (sample !== exp_s) begin
          errors++; $display("FAIL toggle_sample c=%0d: got %0d expected %0d", c, sample, exp_s);
        end
      end
    end
    enable = 1'b0;
    checks++;
    if (pulses !== 2) begin
      errors++; $display("FAIL toggle_pulses: got %0d expected 2", pulses);
    end
  endtask

  task automatic test_sync_clear();
    ftw = 32'h0100_0000; phase_offset = '0; mode = 2'b00;
    mode_seq.delete();
    exp_q = '{8'd128, 8'd131, 8'd134, 8'd137, 8'd140, 8'd128, 8'd131};
    clear_acc();
    run_enabled(8, 5, 8 + LAT + 1);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL clear_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL clear_sample[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    ftw = 32'h0100_0000; phase_offset = '0; mode = 2'b00;
    clear_acc();
    enable = 1'b1;
    repeat (LAT + 3) step();
    checks++;
    if (sample_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_pre_valid: got %0b expected 1", sample_valid);
    end
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (sample !== 8'd0 || sample_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_async: got valid=%0b sample=%0d expected 0/0", sample_valid, sample);
    end
    enable = 1'b0;
    step();
    reset_n = 1'b1;
    enable  = 1'b1;
    for (int c = 0; c < LAT; c++) begin
      step();
      checks++;
      if (sample_valid !== (c == LAT - 1)) begin
        errors++; $display("FAIL midrst_valid c=%0d: got %0b expected %0b", c, sample_valid, (c == LAT - 1));
      end
    end
    checks++;
    if (sample !== 8'd128) begin
      errors++; $display("FAIL midrst_first: got %0d expected 128", sample);
    end
    enable = 1'b0;
    repeat (LAT + 1) step();
  endtask

`ifdef NCO_AMPLITUDE_SCALE_EN
  task automatic test_amplitude();
    ftw = '0; phase_offset = 32'h4000_0000; mode = 2'b00;
    amplitude = 8'd64;
    clear_acc();
    for (int c = 0; c < LAT + 1; c++) begin
      enable = (c == 0);
      step();
      checks++;
      if (sample_valid !== (c == LAT - 1)) begin
        errors++; $display("FAIL amp_valid c=%0d: got %0b expected %0b", c, sample_valid, (c == LAT - 1));
      end
      if (c == LAT - 1) begin
        checks++;
        if (sample !== 8'd191) begin
          errors++; $display("FAIL amp64_sample: got %0d expected 191", sample);
        end
      end
    end
    amplitude = 8'd0;
    mode_seq.delete();
    exp_q = '{8'd128, 8'd128, 8'd128};
    run_enabled(3, -1, 3 + LAT + 1);
    checks++;
    if (got_q != exp_q) begin
      errors++; $display("FAIL amp0_samples: got %p expected %p", got_q, exp_q);
    end
    amplitude    = 8'd128;
    phase_offset = '0;
  endtask
`endif

  initial begin
    reset_n      = 1'b0;
    enable       = 1'b0;
    sync_clear   = 1'b0;
    ftw          = 32'h0100_0000;
    phase_offset = '0;
    mode         = 2'b00;
`ifdef NCO_AMPLITUDE_SCALE_EN
    amplitude    = 8'd128;
`endif
    test_reset();
    test_sine_ramp();
    test_offset();
    test_modes();
    test_mode_pipeline();
    test_enable_toggle();
    test_sync_clear();
    test_reset_midstream();
`ifdef NCO_AMPLITUDE_SCALE_EN
    test_amplitude();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
